// File: rtl/cordic_pipeline.sv
// Fully pipelined circular CORDIC. It applies quadrant pre-rotation, then STAGES micro-rotations,
// then optional gain compensation and output saturation. Each sample carries its strobe and mode bit.

module cordic_stage #(
    parameter int W2     = 18,
    parameter int ZWIDTH = 24,
    parameter int SHIFT  = 0,
    parameter int ALPHA  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode_in,
    input  logic signed [W2-1:0] x_in,
    input  logic signed [W2-1:0] y_in,
    input  logic [ZWIDTH-1:0]    z_in,
    output logic                 mode,
    output logic signed [W2-1:0] x,
    output logic signed [W2-1:0] y,
    output logic [ZWIDTH-1:0]    z
);
    logic                 sigma;
    logic signed [W2-1:0] xsh, ysh;

    always_comb begin
        // sigma=1 rotates counter-clockwise by alpha
        sigma = mode_in ? y_in[W2-1] : ~z_in[ZWIDTH-1];
        xsh   = x_in >>> SHIFT;
        ysh   = y_in >>> SHIFT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode <= 1'b0;
            x    <= '0;
            y    <= '0;
            z    <= '0;
        end else if (en) begin
            mode <= mode_in;
            x    <= sigma ? x_in - ysh : x_in + ysh;
            y    <= sigma ? y_in + xsh : y_in - xsh;
            z    <= sigma ? z_in - ZWIDTH'(ALPHA) : z_in + ZWIDTH'(ALPHA);
        end
    end
endmodule

module cordic_pipeline #(
    parameter int WIDTH     = 16,
    parameter int ZWIDTH    = 24,
    parameter int STAGES    = 16,
    parameter int GAIN_COMP = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stb_in,
    input  logic                     mode_in,
    input  logic signed [WIDTH-1:0]  xi,
    input  logic signed [WIDTH-1:0]  yi,
    input  logic signed [ZWIDTH-1:0] zi,
    output logic                     stb_out,
    output logic                     mode_out,
    output logic signed [WIDTH-1:0]  xo,
    output logic signed [WIDTH-1:0]  yo,
    output logic signed [ZWIDTH-1:0] zo
);
    localparam int  W2  = WIDTH + 2;
    localparam int  LAT = 1 + STAGES + GAIN_COMP;
    localparam real PI  = 3.14159265358979323846;
    localparam logic [ZWIDTH-1:0]    ZHALF = {1'b1, {(ZWIDTH-1){1'b0}}};
    localparam logic signed [W2-1:0] SMAX  = W2'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [W2-1:0] SMIN  = -SMAX - W2'(1);

    function automatic int gain_k();
        real p;
        p = 1.0;
        for (int i = 0; i < STAGES; i++) p = p / $sqrt(1.0 + 2.0 ** (-2 * i));
        return $rtoi(p * 2.0 ** WIDTH + 0.5);
    endfunction

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [W2-1:0] v);
        if (v > SMAX) return SMAX[WIDTH-1:0];
        if (v < SMIN) return SMIN[WIDTH-1:0];
        return v[WIDTH-1:0];
    endfunction

    logic [LAT-1:0]       vld_pipe;
    logic [STAGES:0]      md;
    logic signed [W2-1:0] xs [STAGES+1];
    logic signed [W2-1:0] ys [STAGES+1];
    logic [ZWIDTH-1:0]    zs [STAGES+1];

    logic                 flip, mp;
    logic signed [W2-1:0] xe, ye, xp, yp;
    logic [ZWIDTH-1:0]    zp;
    logic                 mf;
    logic signed [W2-1:0] xf, yf;
    logic [ZWIDTH-1:0]    zf;

    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[LAT-2:0], stb_in};
    end

    // Move the sample into the right half-plane so that the micro-rotations converge.
    always_comb begin
        xe   = W2'(xi);
        ye   = W2'(yi);
        flip = mode_in ? xi[WIDTH-1] : (zi[ZWIDTH-1] ^ zi[ZWIDTH-2]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mp <= 1'b0;
            xp <= '0;
            yp <= '0;
            zp <= '0;
        end else if (stb_in) begin
            mp <= mode_in;
            xp <= flip ? -xe : xe;
            yp <= flip ? -ye : ye;
            zp <= flip ? zi + ZHALF : zi;
        end
    end

    assign md[0] = mp;
    assign xs[0] = xp;
    assign ys[0] = yp;
    assign zs[0] = zp;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam int ALPHA = $rtoi($atan(2.0 ** (-i)) / PI * 2.0 ** (ZWIDTH - 1) + 0.5);
        cordic_stage #(.W2(W2), .ZWIDTH(ZWIDTH), .SHIFT(i), .ALPHA(ALPHA)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (vld_pipe[i]),
            .mode_in (md[i]),
            .x_in    (xs[i]),
            .y_in    (ys[i]),
            .z_in    (zs[i]),
            .mode    (md[i+1]),
            .x       (xs[i+1]),
            .y       (ys[i+1]),
            .z       (zs[i+1])
        );
    end

    if (GAIN_COMP != 0) begin : g_gain
        localparam int PW = W2 + WIDTH + 1;
        localparam logic [WIDTH-1:0]    K    = WIDTH'(gain_k());
        localparam logic signed [PW-1:0] HALF = PW'(1) <<< (WIDTH - 1);
        logic signed [PW-1:0] px, py;
        logic signed [W2-1:0] xg, yg;
        logic [ZWIDTH-1:0]    zg;
        logic                 mg;

        assign px = PW'(xs[STAGES]) * PW'($signed({1'b0, K}));
        assign py = PW'(ys[STAGES]) * PW'($signed({1'b0, K}));

        always_ff @(posedge clk) begin
            if (rst) begin
                mg <= 1'b0;
                xg <= '0;
                yg <= '0;
                zg <= '0;
            end else if (vld_pipe[STAGES]) begin
                mg <= md[STAGES];
                xg <= W2'((px + HALF) >>> WIDTH);
                yg <= W2'((py + HALF) >>> WIDTH);
                zg <= zs[STAGES];
            end
        end

        assign mf = mg;
        assign xf = xg;
        assign yf = yg;
        assign zf = zg;
    end else begin : g_nogain
        assign mf = md[STAGES];
        assign xf = xs[STAGES];
        assign yf = ys[STAGES];
        assign zf = zs[STAGES];
    end

    assign stb_out  = vld_pipe[LAT-1];
    assign mode_out = mf;
    assign xo       = sat(xf);
    assign yo       = sat(yf);
    assign zo       = zf;
endmodule

// File: doc/cordic_pipeline.md
# cordic_pipeline

Fully pipelined, parametrised CORDIC engine for circular coordinates. It processes one sample per clock and selects rotation mode (complex exponential / mixer) or vectoring mode (magnitude/phase, FM discriminator) per sample through a tagged mode bit. It adds full-range quadrant pre-rotation, internal guard bits, optional gain compensation and output saturation. It sits between the DDS/phase accumulator and the I/Q datapath, and replaces per-stage manual instantiation.

## Interface
- WIDTH, 16: signed x/y sample width, Q1.(WIDTH-1).
- ZWIDTH, 24: signed angle width; z = angle/pi * 2^(ZWIDTH-1), so full scale [-pi, pi) wraps naturally.
- STAGES, 16: number of micro-rotation stages, i = 0..STAGES-1; legal range 1..min(WIDTH+2, 32).
- GAIN_COMP, 1: 1 inserts a gain-compensation stage (multiply by K); 0 omits it (outputs scaled by ~1.6468).

- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- stb_in  input  1  input sample valid.
- mode_in  input  1  0 = rotation (drive z to 0), 1 = vectoring (drive y to 0).
- xi  input  WIDTH  signed x.
- yi  input  WIDTH  signed y.
- zi  input  ZWIDTH  signed angle.
- stb_out  output  1  output sample valid.
- mode_out  output  1  mode tag of the sample on the outputs.
- xo  output  WIDTH  signed x result, saturated.
- yo  output  WIDTH  signed y result, saturated.
- zo  output  ZWIDTH  signed angle result, wraps modulo 2pi.

## Operation
- Internal x/y width is W2 = WIDTH+2. Inputs are sign-extended, and no internal stage saturates.
- Stage P (pre-rotation, registered):
  - Rotation mode: if zi[Z-1] xor zi[Z-2] (|angle| > pi/2), then x=-x, y=-y and z = zi + 2^(ZWIDTH-1), with modulo wrap.
  - Vectoring mode: if xi < 0, then x=-x, y=-y and z = zi + 2^(ZWIDTH-1).
  - Otherwise the values pass through.
- Stage i (registered), with sigma = ~z[msb] in rotation and sigma = y[msb] in vectoring:
  - x' = x - (sigma ? y>>>i : -(y>>>i))
  - y' = y + (sigma ? x>>>i : -(x>>>i))
  - z' = z - (sigma ? alpha_i : -alpha_i)
  - >>> is an arithmetic shift. alpha_i = round(atan(2^-i)/pi * 2^(ZWIDTH-1)), computed at elaboration.
- Stage G (present only if GAIN_COMP=1): x,y *= K.
  - K = round(prod_{i<STAGES} 1/sqrt(1+2^-2i) * 2^WIDTH), unsigned.
  - The product is shifted right by WIDTH with round-half-up.
- Output: x/y saturate from W2 to WIDTH bits (max 2^(WIDTH-1)-1, min -2^(WIDTH-1)). z is truncated to ZWIDTH, modulo wrap, never saturated.
- The mode bit and strobe travel with each sample through every stage.
- A stage register loads only when its incoming strobe is 1 and holds otherwise. Outputs hold the last result while stb_out=0.
- No backpressure: the pipeline never stalls and accepts stb_in every cycle.
- A mode change between consecutive samples has no effect on neighbouring samples.

## Timing
- Latency L = 1 + STAGES + GAIN_COMP cycles (default 18). Output saturation is combinational on the last register.
- stb_out is high exactly L cycles after stb_in is sampled high, one-for-one. Gaps in the input produce identical gaps in the output.
- Reset: on the clk edge where rst=1, all stage registers, strobes and mode tags clear.
  - xo=0, yo=0, zo=0, mode_out=0, stb_out=0 from that edge until a new sample emerges.
  - In-flight samples are discarded, not flushed.
  - The first stb_in sampled with rst=0 produces stb_out L cycles later.
- stb_in is ignored in any cycle where rst=1.

## Test plan
- Rotation, mode_in=0, x=16384, y=0, z=0x200000 (pi/4), defaults:
  - L=18, then xo = yo = 11585 ±4, zo = 0 ±32, mode_out=0.
- Rotation quadrant, x=16384, y=0, z=0x600000 (3pi/4):
  - xo = -11585 ±4, yo = 11585 ±4.
  - Repeat with z=0xA00000 (-3pi/4): xo = -11585 ±4, yo = -11585 ±4.
- Vectoring, mode_in=1:
  - x=0, y=16384, z=0: xo = 16384 ±4, yo = 0 ±4, zo = 0x400000 ±32.
  - x=-16384, y=0: xo = 16384 ±4, zo = 0x800000 ±32 (-pi wrap).
- Throughput/tagging: 64 back-to-back strobes with alternating mode_in and random x/y/z, then 3 idle cycles, then 10 more strobes.
  - stb_out pattern is identical to the input pattern delayed by L.
  - mode_out matches per sample.
  - Results match a bit-accurate model exactly.
- Saturation: GAIN_COMP=0, vectoring, x=y=32767.
  - xo = 32767 (saturated), yo = 0 ±4, zo = 0x200000 ±32.
- Reset mid-flight: 10 strobes, rst high for 1 cycle at cycle 5.
  - All outputs are 0 the next cycle.
  - No stb_out from the discarded samples.
  - A sample issued 2 cycles after reset appears exactly L cycles later.
